sensor_scanner: RTL and testbench

Sequential scan controller for the train-track sensor multiplexer (`Syncronizer`). It drives the mux `Selector`/`Enable` inputs, steps through sensors S1..S6 in a fixed round-robin, and samples the mux output `Y` after a settle window. Each channel is debounced over consecutive scans. The block publishes a stable 6-bit sensor vector plus a one-cycle change event to the train control FSM.

---
 rtl/train_pkg.sv | 16 +
 rtl/sensor_scanner_if.sv | 42 ++++
 rtl/sensor_debounce.sv | 49 ++++
 rtl/sensor_scanner.sv | 136 +++++++++++++
 tb/tb_sensor_scanner.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/train_pkg.sv
// Shared constants and types for the train-track sensor scanner.
// Selector codes map scan channel 0..5 to mux inputs S1..S6.
package train_pkg;

  localparam int unsigned NUM_SENSORS = 6;

  localparam logic [7:0] SEL_IDLE = 8'd0;
  localparam logic [7:0] SEL_CODE [NUM_SENSORS] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StSample
  } scan_state_e;

endpackage

// File: rtl/sensor_scanner_if.sv
// Bundle between the scanner, the sensor mux and the train control FSM.
// master = scanner side; slave = the mux/controller environment.
interface sensor_scanner_if #(
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned NUM_SENSORS = 6
);

  logic                   scan_en;
  logic [SEL_W-1:0]       sel;
  logic                   sel_enable;
  logic                   y;
  logic [NUM_SENSORS-1:0] sensors;
  logic                   change_valid;
  logic [2:0]             change_idx;
  logic                   change_level;
  logic                   scan_done;

  modport master (
    input  scan_en,
    input  y,
    output sel,
    output sel_enable,
    output sensors,
    output change_valid,
    output change_idx,
    output change_level,
    output scan_done
  );

  modport slave (
    output scan_en,
    output y,
    input  sel,
    input  sel_enable,
    input  sensors,
    input  change_valid,
    input  change_idx,
    input  change_level,
    input  scan_done
  );

endinterface

// File: rtl/sensor_debounce.sv
// Single-channel debouncer: the stable level flips after DEBOUNCE_COUNT
// consecutive enabled samples that disagree with it.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en_i,
  input  logic sample_i,
  output logic stable_o,
  output logic flip_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_COUNT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_o   = 1'b0;
    if (sample_en_i) begin
      if (sample_i == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEBOUNCE_COUNT - 1)) begin
        // This disagreeing sample is the one that reaches the threshold.
        cnt_d    = '0;
        stable_d = ~stable_q;
        flip_o   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sensor_scanner.sv
// Round-robin scan controller for the sensor mux: selects each channel, waits
// a settle window, samples y, debounces, and reports level changes.
module sensor_scanner #(
  parameter int unsigned NUM_SENSORS    = 6,
  parameter int unsigned SEL_W          = 5,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sensor_scanner_if.master   bus
);

  import train_pkg::*;

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [2:0]  LastCh  = 3'(NUM_SENSORS - 1);

  scan_state_e        state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic               sample_en;

  logic [NUM_SENSORS-1:0] stable;
  logic [NUM_SENSORS-1:0] flip;

  logic       change_valid_q, change_valid_d;
  logic [2:0] change_idx_q, change_idx_d;
  logic       change_level_q, change_level_d;
  logic       scan_done_q, scan_done_d;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    settle_d  = settle_q;
    sample_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.scan_en) begin
          state_d  = StSelect;
          ch_d     = '0;
          settle_d = '0;
        end
      end
      StSelect: begin
        if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StSample: begin
        sample_en = 1'b1;
        settle_d  = '0;
        // scan_en is only honoured at channel boundaries.
        if (!bus.scan_en) begin
          state_d = StIdle;
          ch_d    = '0;
        end else begin
          state_d = StSelect;
          ch_d    = (ch_q == LastCh) ? 3'd0 : ch_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      settle_q <= settle_d;
    end
  end

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    sensor_debounce #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en_i(sample_en && (ch_q == 3'(i))),
      .sample_i   (bus.y),
      .stable_o   (stable[i]),
      .flip_o     (flip[i])
    );
  end

  always_comb begin
    change_valid_d = 1'b0;
    change_idx_d   = change_idx_q;
    change_level_d = change_level_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (flip[i]) begin
        change_valid_d = 1'b1;
        change_idx_d   = 3'(i);
        change_level_d = ~stable[i];
      end
    end
    scan_done_d = sample_en && (ch_q == LastCh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      change_valid_q <= 1'b0;
      change_idx_q   <= '0;
      change_level_q <= 1'b0;
      scan_done_q    <= 1'b0;
    end else begin
      change_valid_q <= change_valid_d;
      change_idx_q   <= change_idx_d;
      change_level_q <= change_level_d;
      scan_done_q    <= scan_done_d;
    end
  end

  always_comb begin
    bus.sel        = SEL_W'(SEL_IDLE);
    bus.sel_enable = 1'b0;
    if (state_q != StIdle) begin
      bus.sel        = SEL_W'(SEL_CODE[ch_q]);
      bus.sel_enable = 1'b1;
    end
  end

  assign bus.sensors      = stable;
  assign bus.change_valid = change_valid_q;
  assign bus.change_idx   = change_idx_q;
  assign bus.change_level = change_level_q;
  assign bus.scan_done    = scan_done_q;

endmodule

// File: tb/tb_sensor_scanner.sv
// Self-checking bench for sensor_scanner: change events are scoreboarded,
// selector sequence and idle/stop behaviour are checked per test.
module tb_sensor_scanner;

  localparam int unsigned ScanLen = 18;

  typedef struct packed {
    logic [2:0] idx;
    logic       level;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] model = 6'b0;

  int total = 0;
  int bad   = 0;

  ev_t exp_q[$];
  ev_t ev;
  logic [4:0] sel_q[$];

  sensor_scanner_if #(.SEL_W(5), .NUM_SENSORS(6)) bus ();

  sensor_scanner #(
    .NUM_SENSORS   (6),
    .SEL_W         (5),
    .SETTLE_CYCLES (2),
    .DEBOUNCE_COUNT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Mux model: y follows the selected sensor while enabled.
  always_comb begin
    bus.y = 1'b0;
    if (bus.sel_enable && bus.sel >= 5'd1 && bus.sel <= 5'd6) begin
      bus.y = model[3'(bus.sel - 5'd1)];
    end
  end

  always @(negedge clk) begin
    if (bus.change_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL change_event: got idx=%0d level=%0d, required no event",
                 bus.change_idx, bus.change_level);
      end else begin
        ev = exp_q.pop_front();
        if (bus.change_idx !== ev.idx || bus.change_level !== ev.level) begin
          bad++;
          $display("FAIL change_event: got idx=%0d level=%0d, required idx=%0d level=%0d",
                   bus.change_idx, bus.change_level, ev.idx, ev.level);
        end
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.scan_en = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    run_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic check_queue(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected change events missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.scan_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.sel !== 5'd0 || bus.sel_enable !== 1'b0 || bus.sensors !== 6'd0 ||
          bus.change_valid !== 1'b0 || bus.change_idx !== 3'd0 ||
          bus.change_level !== 1'b0 || bus.scan_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: got sel=%0d en=%b sens=%b cv=%b ci=%0d cl=%b sd=%b, required all 0",
                 bus.sel, bus.sel_enable, bus.sensors, bus.change_valid, bus.change_idx,
                 bus.change_level, bus.scan_done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sel !== 5'd1 || bus.sel_enable !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_sel: got sel=%0d en=%b, required sel=1 en=1",
               bus.sel, bus.sel_enable);
    end
  endtask

  task automatic test_sequence();
    logic [4:0] exp_sel;
    logic       exp_done;
    do_reset();
    model = 6'b0;
    for (int n = 0; n < 2 * ScanLen + 1; n++) sel_q.push_back(5'((n / 3) % 6 + 1));
    bus.scan_en = 1'b1;
    for (int n = 0; n < 2 * ScanLen + 1; n++) begin
      @(negedge clk);
      exp_sel  = sel_q.pop_front();
      exp_done = (n > 0) && (n % ScanLen == 0);
      total++;
      if (bus.sel !== exp_sel || bus.sel_enable !== 1'b1) begin
        bad++;
        $display("FAIL seq_sel[%0d]: got sel=%0d en=%b, required sel=%0d en=1",
                 n, bus.sel, bus.sel_enable, exp_sel);
      end
      total++;
      if (bus.scan_done !== exp_done) begin
        bad++;
        $display("FAIL seq_scan_done[%0d]: got %b, required %b", n, bus.scan_done, exp_done);
      end
    end
    check_queue("seq_no_change");
  endtask

  task automatic test_assert_release();
    do_reset();
    model = 6'b000100;
    exp_q.push_back('{idx: 3'd2, level: 1'b1});
    bus.scan_en = 1'b1;
    run_cycles(4 * ScanLen);
    check_queue("assert_event");
    total++;
    if (bus.sensors !== 6'b000100) begin
      bad++;
      $display("FAIL assert_sensors: got %b, required 000100", bus.sensors);
    end
    run_cycles(ScanLen);
    total++;
    if (bus.sensors !== 6'b000100) begin
      bad++;
      $display("FAIL assert_hold: got %b, required 000100", bus.sensors);
    end
    model = 6'b0;
    exp_q.push_back('{idx: 3'd2, level: 1'b0});
    run_cycles(4 * ScanLen + 2);
    check_queue("release_event");
    total++;
    if (bus.sensors !== 6'b000000) begin
      bad++;
      $display("FAIL release_sensors: got %b, required 000000", bus.sensors);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    model = 6'b000100;
    bus.scan_en = 1'b1;
    run_cycles(3 * ScanLen);
    model = 6'b0;
    run_cycles(2 * ScanLen);
    check_queue("glitch_no_change");
    total++;
    if (bus.sensors !== 6'b000000) begin
      bad++;
      $display("FAIL glitch_sensors: got %b, required 000000", bus.sensors);
    end
  endtask

  task automatic test_stop();
    do_reset();
    model = 6'b001000;
    bus.scan_en = 1'b1;
    run_cycles(3 * ScanLen);
    // Fourth sample of channel 3 flips it, proving the channel completed.
    exp_q.push_back('{idx: 3'd3, level: 1'b1});
    run_cycles(10);
    total++;
    if (bus.sel !== 5'd4) begin
      bad++;
      $display("FAIL stop_in_ch3: got sel=%0d, required 4", bus.sel);
    end
    bus.scan_en = 1'b0;
    run_cycles(3);
    total++;
    if (bus.sel !== 5'd0 || bus.sel_enable !== 1'b0) begin
      bad++;
      $display("FAIL stop_idle: got sel=%0d en=%b, required sel=0 en=0", bus.sel, bus.sel_enable);
    end
    total++;
    if (bus.sensors !== 6'b001000) begin
      bad++;
      $display("FAIL stop_sensors: got %b, required 001000", bus.sensors);
    end
    run_cycles(3);
    total++;
    if (bus.sel !== 5'd0 || bus.sel_enable !== 1'b0) begin
      bad++;
      $display("FAIL stop_stay_idle: got sel=%0d en=%b, required sel=0 en=0",
               bus.sel, bus.sel_enable);
    end
    check_queue("stop_event");
    bus.scan_en = 1'b1;
    run_cycles(1);
    total++;
    if (bus.sel !== 5'd1 || bus.sel_enable !== 1'b1) begin
      bad++;
      $display("FAIL stop_restart: got sel=%0d en=%b, required sel=1 en=1",
               bus.sel, bus.sel_enable);
    end
  endtask

  initial begin
    bus.scan_en = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_sequence();
    test_assert_release();
    test_glitch();
    test_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
